// File: rtl/hier_next_state_logic.sv
// Next-state and dwell-timing half of the hierarchical 3-bit FSM (IDLE, RUN S1-S3, SERVICE S4-S6, FAULT).
// Define FSM_WATCHDOG_EN to force FAULT after WDT_LIMIT consecutive paused cycles in RUN/SERVICE.
module hier_next_state_logic #(
  parameter int DWELL_RUN = 4,
  parameter int DWELL_SVC = 2,
  parameter int CNT_W     = 4,
  parameter int WDT_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       current_state,
  input  logic             start,
  input  logic             pause,
  input  logic             fault,
  input  logic             clear,
  output logic [2:0]       next_state,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic             cycle_done,
  output logic [7:0]       run_count
);

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(DWELL_RUN - 1);
  localparam logic [CNT_W-1:0] SVC_LAST = CNT_W'(DWELL_SVC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           cur_s;
  state_t           nxt_s;
  logic             active_s;
  logic             exp_run_s;
  logic             exp_svc_s;
  logic             wdt_trip_s;
  logic             done_s;
  logic [CNT_W-1:0] dwell_r;
  logic             cycle_done_r;
  logic [7:0]       run_count_r;

  assign cur_s     = state_t'(current_state);
  assign active_s  = (cur_s != S0) && (cur_s != S7);
  assign exp_run_s = (dwell_r == RUN_LAST) && !pause;
  assign exp_svc_s = (dwell_r == SVC_LAST) && !pause;

  // Next-state selection: reset, then fault/watchdog, then per-state progression.
  always_comb begin
    nxt_s = cur_s;
    if (!rst) begin
      nxt_s = S0;
    end else if (fault || wdt_trip_s) begin
      nxt_s = S7;
    end else begin
      case (cur_s)
        S0:      nxt_s = start     ? S1 : S0;
        S1:      nxt_s = exp_run_s ? S2 : S1;
        S2:      nxt_s = exp_run_s ? S3 : S2;
        S3:      nxt_s = exp_run_s ? S4 : S3;
        S4:      nxt_s = exp_svc_s ? S5 : S4;
        S5:      nxt_s = exp_svc_s ? S6 : S5;
        S6:      nxt_s = exp_svc_s ? S0 : S6;
        S7:      nxt_s = clear     ? S0 : S7;
        default: nxt_s = S0;
      endcase
    end
  end

  assign done_s = (cur_s == S6) && (nxt_s == S0);

  // Dwell counter, completion pulse and saturating completed-cycle count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell_r      <= '0;
      cycle_done_r <= 1'b0;
      run_count_r  <= 8'd0;
    end else begin
      if ((nxt_s != cur_s) || !active_s) begin
        dwell_r <= '0;
      end else if (!pause) begin
        dwell_r <= dwell_r + CNT_ONE;
      end else begin
        dwell_r <= dwell_r;
      end
      cycle_done_r <= done_s;
      if (done_s && (run_count_r != 8'hFF)) begin
        run_count_r <= run_count_r + 8'd1;
      end else begin
        run_count_r <= run_count_r;
      end
    end
  end

`ifdef FSM_WATCHDOG_EN
  localparam int               WDT_W    = $clog2(WDT_LIMIT + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_LIMIT - 1);
  localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);

  logic [WDT_W-1:0] wdt_r;

  // Trips on the WDT_LIMIT-th consecutive paused cycle inside RUN/SERVICE.
  assign wdt_trip_s = active_s && pause && (wdt_r == WDT_LAST);

  // Consecutive-pause watchdog; any break in the pause run restarts it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdt_r <= '0;
    end else if (wdt_trip_s || !pause || !active_s || (nxt_s == S0) || (nxt_s == S7)) begin
      wdt_r <= '0;
    end else begin
      wdt_r <= wdt_r + WDT_ONE;
    end
  end
`else
  // Without the watchdog a pause may hold a RUN/SERVICE state indefinitely.
  assign wdt_trip_s = (WDT_LIMIT < 32'sd0);
`endif

  assign next_state = nxt_s;
  assign dwell_cnt  = dwell_r;
  assign cycle_done = cycle_done_r;
  assign run_count  = run_count_r;

endmodule

// File: doc/hier_next_state_logic.md
Name: hier_next_state_logic

Overview:
- Next-state and dwell-timing half of the hierarchical 3-bit FSM.
- Consumes `current_state` from the state register and produces `next_state` back into it, closing the loop.
- Super-states:
  - IDLE (S0)
  - RUN (sub-states S1-S3)
  - SERVICE (sub-states S4-S6)
  - FAULT (S7)
- Holds the sequential context: dwell counter, watchdog, completed-cycle count.

Parameters:
- DWELL_RUN, 4: cycles each RUN sub-state is held (legal 1..2^CNT_W-1).
- DWELL_SVC, 2: cycles each SERVICE sub-state is held (legal 1..2^CNT_W-1).
- CNT_W, 4: width of the dwell counter.
- WDT_LIMIT, 16: consecutive pause cycles before watchdog fault. Used only with FSM_WATCHDOG_EN.

Ports:
- clk  input  1  system clock, all flops on rising edge.
- rst  input  1  synchronous active-low reset. Sampled on rising edge of clk; 0 = reset.
- current_state  input  3  registered state from the state register (S0=000 .. S7=111).
- start  input  1  level; leave IDLE.
- pause  input  1  level; freeze RUN/SERVICE progress.
- fault  input  1  level; enter FAULT.
- clear  input  1  level; exit FAULT.
- next_state  output  3  combinational next state.
- dwell_cnt  output  CNT_W  cycles spent in current sub-state.
- cycle_done  output  1  registered one-cycle pulse per completed S6->S0.
- run_count  output  8  completed cycles, saturating.

Behaviour:
- Reset (rst=0 at a clock edge):
  - dwell_cnt=0, cycle_done=0, run_count=0, watchdog count=0.
  - next_state is forced to S0 combinationally whenever rst=0.
- Expiry conditions:
  - exp_run = (dwell_cnt == DWELL_RUN-1) && !pause
  - exp_svc = (dwell_cnt == DWELL_SVC-1) && !pause
- Transition priority, highest first:
  1. rst=0 -> S0.
  2. fault=1 in any state -> S7.
  3. Per-state rules:
     - S0: start -> S1, else S0. pause ignored.
     - S1 -> S2, S2 -> S3, S3 -> S4 on exp_run; otherwise hold.
     - S4 -> S5, S5 -> S6, S6 -> S0 on exp_svc; otherwise hold.
     - S7: clear && !fault -> S0, else S7. pause ignored.
- Dwell counter, per clock edge:
  - Cleared to 0 when next_state != current_state, or in S0/S7.
  - Holds when pause=1 in S1-S6.
  - Otherwise increments.
  - Never exceeds DWELL_x-1, so no wrap.
- cycle_done <= (current_state==S6 && next_state==S0). It is high during the first cycle current_state reads S0, low otherwise.
- run_count increments on the same condition as cycle_done; saturates at 255.
- Simultaneous events:
  - fault together with expiry: fault wins. No cycle_done, no run_count increment.
  - start together with fault in S0: goes to S7.
  - clear together with fault in S7: stays in S7.
- Mid-operation reset: next_state=S0 in the same cycle; counters zeroed at the edge; no cycle_done.
- Expected end-to-end latency with a registered current_state: start sampled -> 1 cycle in S1 registration. A full S1..S6 pass takes 3*DWELL_RUN + 3*DWELL_SVC cycles (18 at defaults).

Optional Feature:
- Macro: FSM_WATCHDOG_EN.
- When defined:
  - A watchdog counter counts consecutive cycles with pause=1 while in S1-S6.
  - It clears on pause=0, on entry to S0/S7, and on reset.
  - On reaching WDT_LIMIT, next_state=S7 (same priority as fault). The counter then clears.
- When undefined: no watchdog logic; pause may hold state indefinitely.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, start=0 -> next_state=S0, dwell_cnt=0, run_count=0, cycle_done=0.
- Full cycle at defaults: 1-cycle start pulse -> S1,S2,S3 held 4 cycles each, S4,S5,S6 held 2 cycles each, S0 after 18 cycles. cycle_done is a single pulse; run_count=1.
- Pause: assert pause 5 cycles at S2 with dwell_cnt=2 -> state S2 and dwell_cnt=2 frozen; resume -> S3 exactly 2 cycles later (1 more to reach 3, then transition).
- Fault/clear: fault at S5 expiry cycle -> S7 with no cycle_done. clear=1 with fault=1 -> stays S7. Drop fault -> S0 next cycle.
- Saturation and mid-reset:
  - Run 256 cycles -> run_count holds 255.
  - rst=0 while in S3 -> S0, all counters 0 the next cycle.
- With FSM_WATCHDOG_EN, WDT_LIMIT=16: hold pause 16 cycles in S4 -> S7. With 15 cycles of pause then release -> normal S5 progression.
